// File: rtl/iso_rx_pkg.sv
// Shared types, constants and helpers for the ISO7816-3 character receiver.
package iso_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      GUARD  = 3'd4,
      ERRSIG = 3'd5
   } rx_state_t;

   localparam int DEFAULT_ETU = 372;
   localparam int MIN_ETU     = 8;

   // Zero selects the default ETU; tiny values are clamped so the half-ETU
   // sample point stays well clear of the synchroniser latency.
   function automatic int effective_etu(input int requested,
                                        input int default_etu,
                                        input int min_etu);
      int result;
      if (requested == 0)
         result = default_etu;
      else if (requested < min_etu)
         result = min_etu;
      else
         result = requested;
      return result;
   endfunction

endpackage

// File: rtl/iso_char_rx_if.sv
// Signal bundle between the character receiver and its environment.
// The master side is the receiver itself; the slave side is the card model
// and the downstream TS/ATR analysis logic.
interface iso_char_rx_if #(
   parameter int ETU_W = 12
);
   logic             enable;
   logic             isoSio;
   logic [ETU_W-1:0] clocksPerEtu;
   logic             errSigEn;
   logic [7:0]       rxData;
   logic             endOfRx;
   logic             parityError;
   logic             sioDriveLow;
   logic             busy;

   modport master (
      input  enable, isoSio, clocksPerEtu, errSigEn,
      output rxData, endOfRx, parityError, sioDriveLow, busy
   );

   modport slave (
      output enable, isoSio, clocksPerEtu, errSigEn,
      input  rxData, endOfRx, parityError, sioDriveLow, busy
   );
endinterface

// File: rtl/iso_etu_timer.sv
// ETU timing for one character: latches the effective clocks-per-ETU at the
// start edge and provides half-ETU and full-ETU ticks from a wrapping counter.
module iso_etu_timer #(
   parameter int ETU_W       = 12,
   parameter int DEFAULT_ETU = iso_rx_pkg::DEFAULT_ETU,
   parameter int MIN_ETU     = iso_rx_pkg::MIN_ETU
) (
   input  logic             isoClk,
   input  logic             nReset,
   input  logic             start,
   input  logic             restart,
   input  logic [ETU_W-1:0] clocksPerEtu,
   output logic             halfTick,
   output logic             etuTick
);
   import iso_rx_pkg::*;

   logic [ETU_W-1:0] etu_reg;
   logic [ETU_W-1:0] cnt;
   logic [ETU_W-1:0] etu_req;
   logic [ETU_W-1:0] full_last;
   logic [ETU_W-1:0] half_last;

   assign etu_req   = ETU_W'(effective_etu(int'(clocksPerEtu), DEFAULT_ETU, MIN_ETU));
   assign full_last = etu_reg - ETU_W'(1);
   assign half_last = (etu_reg >> 1) - ETU_W'(1);
   assign halfTick  = (cnt == half_last);
   assign etuTick   = (cnt == full_last);

   // Start latches the ETU for the whole character; restart only realigns
   // the counter (start bit confirmed). Otherwise count 0..E-1 and wrap.
   always_ff @(posedge isoClk or negedge nReset) begin
      if (!nReset) begin
         etu_reg <= ETU_W'(DEFAULT_ETU);
         cnt     <= '0;
      end else if (start) begin
         etu_reg <= etu_req;
         cnt     <= '0;
      end else if (restart || etuTick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ETU_W'(1);
      end
   end

endmodule

// File: rtl/iso_char_rx.sv
// ISO7816-3 character receiver: synchronises the card I/O line, deframes
// start + 8 data bits (LSB first) + even parity, reports the byte with a
// one-cycle endOfRx pulse and optionally signals a parity error on the line.
module iso_char_rx #(
   parameter int ETU_W       = 12,
   parameter int DEFAULT_ETU = iso_rx_pkg::DEFAULT_ETU,
   parameter int MIN_ETU     = iso_rx_pkg::MIN_ETU
) (
   input logic           nReset,
   input logic           isoClk,
   iso_char_rx_if.master bus
);
   import iso_rx_pkg::*;

   rx_state_t  state;
   logic       sync_meta;
   logic       s;
   logic       s_d;
   logic       fall;
   logic       half_tick;
   logic       etu_tick;
   logic       err_pending;
   logic       start_char;
   logic       restart_etu;
   logic [7:0] shift_reg;
   logic [2:0] bit_idx;

   assign fall        = s_d & ~s;
   assign err_pending = bus.parityError & bus.errSigEn;

   // A start edge is taken in IDLE, and also on the very cycle the guard time
   // ends: the edge detector output for a character sent exactly 10.5 ETU
   // after the previous one lands on that cycle, which is the first moment
   // the receiver is free again.
   assign start_char  = bus.enable & fall &
                        ((state == IDLE) |
                         ((state == GUARD) & etu_tick & ~err_pending));
   assign restart_etu = bus.enable & (state == START) & half_tick & ~s;

   iso_etu_timer #(
      .ETU_W       (ETU_W),
      .DEFAULT_ETU (DEFAULT_ETU),
      .MIN_ETU     (MIN_ETU)
   ) u_timer (
      .isoClk       (isoClk),
      .nReset       (nReset),
      .start        (start_char),
      .restart      (restart_etu),
      .clocksPerEtu (bus.clocksPerEtu),
      .halfTick     (half_tick),
      .etuTick      (etu_tick)
   );

   // Two-flop synchroniser plus one delayed copy for falling-edge detection;
   // resets to the idle (high) line level so reset release never looks like
   // a start bit.
   always_ff @(posedge isoClk or negedge nReset) begin
      if (!nReset) begin
         sync_meta <= 1'b1;
         s         <= 1'b1;
         s_d       <= 1'b1;
      end else begin
         sync_meta <= bus.isoSio;
         s         <= sync_meta;
         s_d       <= s;
      end
   end

   // Character FSM with registered outputs; dropping enable aborts to IDLE
   // while keeping the last received byte and parity result.
   always_ff @(posedge isoClk or negedge nReset) begin
      if (!nReset) begin
         state           <= IDLE;
         shift_reg       <= '0;
         bit_idx         <= '0;
         bus.rxData      <= '0;
         bus.endOfRx     <= 1'b0;
         bus.parityError <= 1'b0;
         bus.sioDriveLow <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         bus.endOfRx <= 1'b0;
         if (!bus.enable) begin
            state           <= IDLE;
            bus.sioDriveLow <= 1'b0;
            bus.busy        <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_char) begin
                     state    <= START;
                     bus.busy <= 1'b1;
                  end
               end
               START: begin
                  if (half_tick) begin
                     if (s) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                     end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                     end
                  end
               end
               DATA: begin
                  if (etu_tick) begin
                     shift_reg[bit_idx] <= s;
                     bit_idx            <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7)
                        state <= PARITY;
                  end
               end
               PARITY: begin
                  if (etu_tick) begin
                     bus.rxData      <= shift_reg;
                     bus.parityError <= (^shift_reg) ^ s;
                     bus.endOfRx     <= 1'b1;
                     state           <= GUARD;
                  end
               end
               GUARD: begin
                  if (etu_tick) begin
                     if (err_pending) begin
                        state           <= ERRSIG;
                        bus.sioDriveLow <= 1'b1;
                     end else if (start_char) begin
                        state <= START;
                     end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                     end
                  end
               end
               ERRSIG: begin
                  if (etu_tick) begin
                     state           <= IDLE;
                     bus.sioDriveLow <= 1'b0;
                     bus.busy        <= 1'b0;
                  end
               end
               default: begin
                  state           <= IDLE;
                  bus.sioDriveLow <= 1'b0;
                  bus.busy        <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
